// File: rtl/bus_pkg.sv
// Shared definitions for the system-bus arbiter: FSM states, channel limits
// and well-known channel indices.
package bus_pkg;

   localparam int unsigned BUS_N_CH_MAX = 32;

   localparam int unsigned CH_ICACHE = 0;
   localparam int unsigned CH_DCACHE = 1;

   typedef enum logic [1:0] {
      StIdle,
      StGrant,
      StRelease
   } bus_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection: fixed priority from channel 0, or round-robin
// starting at ptr, using a double-width masked priority encoder.
module rr_picker #(
   parameter int unsigned N_CH = 8,
   localparam int unsigned CW = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CW-1:0]   ptr,
   input  logic            rr_en,
   output logic [N_CH-1:0] win,
   output logic [CW-1:0]   win_idx,
   output logic            any
);

   logic [2*N_CH-1:0] dbl;
   logic [2*N_CH-1:0] masked;
   logic              found;

   always_comb begin
      dbl     = {req, req};
      masked  = '0;
      win_idx = '0;
      found   = 1'b0;
      // Upper copy is never masked, so the search wraps from N_CH-1 back to 0.
      for (int i = 0; i < 2 * N_CH; i++) begin
         masked[i] = dbl[i] && (!rr_en || (i >= int'(ptr)));
      end
      for (int i = 0; i < 2 * N_CH; i++) begin
         if (!found && masked[i]) begin
            found   = 1'b1;
            win_idx = CW'(i % N_CH);
         end
      end
      any = |req;
      win = any ? (N_CH'(1) << win_idx) : '0;
   end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared system-bus arbiter: grants one of N_CH masters, holds the grant until
// BUS_ready, inserts a one-cycle turnaround, and releases stuck grants on timeout.
module bus_arbiter_rr
   import bus_pkg::*;
#(
   parameter int unsigned N_CH    = 8,
   parameter int unsigned RR_MODE = 1,
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned CW     = $clog2(N_CH)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [N_CH-1:0] DMA,
   input  logic            BUS_ready,
   output logic [N_CH-1:0] grant,
   output logic            BUS_req,
   output logic [CW-1:0]   owner,
   output logic            busy,
   output logic            timeout_err
);

   localparam int unsigned   TW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Counter value seen on the edge that expires the grant (TIMEOUT edges after grant).
   localparam logic [TW-1:0] CNT_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
   localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);

   bus_state_e      state_q, state_d;
   logic [N_CH-1:0] grant_q, grant_d;
   logic [CW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            terr_q, terr_d;

   logic [N_CH-1:0] win;
   logic [CW-1:0]   win_idx;
   logic            any;

   rr_picker #(
      .N_CH(N_CH)
   ) u_picker (
      .req    (DMA),
      .ptr    (ptr_q),
      .rr_en  (RR_MODE != 0),
      .win    (win),
      .win_idx(win_idx),
      .any    (any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any) begin
               state_d = StGrant;
               grant_d = win;
               owner_d = win_idx;
               cnt_d   = '0;
               ptr_d   = (win_idx == LAST_CH) ? '0 : win_idx + 1'b1;
            end
         end
         StGrant: begin
            if (BUS_ready || !DMA[owner_q]) begin
               state_d = StRelease;
               grant_d = '0;
               owner_d = '0;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d = StRelease;
               grant_d = '0;
               owner_d = '0;
               terr_d  = 1'b1;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StRelease: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= StIdle;
         grant_q <= '0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         terr_q  <= terr_d;
      end
   end

   assign grant       = grant_q;
   assign BUS_req     = |grant_q;
   assign owner       = owner_q;
   assign busy        = (state_q != StIdle);
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: round-robin instance with TIMEOUT=4 and a
// fixed-priority instance, checked against hand-computed cycle-by-cycle values.
module tb_bus_arbiter_rr;
   import bus_pkg::*;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic [7:0] dma = '0;
   logic       ready = 1'b0;
   logic [7:0] grant;
   logic       bus_req;
   logic [2:0] owner;
   logic       busy;
   logic       terr;

   logic [7:0] dma_fp = '0;
   logic       ready_fp = 1'b0;
   logic [7:0] grant_fp;
   logic       bus_req_fp;
   logic [2:0] owner_fp;
   logic       busy_fp;
   logic       terr_fp;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bus_arbiter_rr #(.N_CH(8), .RR_MODE(1), .TIMEOUT(4)) dut (
      .clk        (clk),
      .clr        (clr),
      .DMA        (dma),
      .BUS_ready  (ready),
      .grant      (grant),
      .BUS_req    (bus_req),
      .owner      (owner),
      .busy       (busy),
      .timeout_err(terr)
   );

   bus_arbiter_rr #(.N_CH(8), .RR_MODE(0), .TIMEOUT(4)) dut_fp (
      .clk        (clk),
      .clr        (clr),
      .DMA        (dma_fp),
      .BUS_ready  (ready_fp),
      .grant      (grant_fp),
      .BUS_req    (bus_req_fp),
      .owner      (owner_fp),
      .busy       (busy_fp),
      .timeout_err(terr_fp)
   );

   // Advance one rising edge, then settle so outputs are sampled away from it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clr = 1'b1;
      dma = '0;
      ready = 1'b0;
      dma_fp = '0;
      ready_fp = 1'b0;
      step();
      step();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      clr = 1'b1;
      dma = 8'hFF;
      ready = 1'b0;
      step();
      step();
      n_vec++;
      if ({grant, bus_req, owner, busy, terr} !== 14'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got grant=%h req=%b owner=%0d busy=%b terr=%b want all 0",
                  grant, bus_req, owner, busy, terr);
      end
      n_vec++;
      if (dut.ptr_q !== 3'd0) begin
         n_err++;
         $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
      end
      clr = 1'b0;
      step();
      n_vec++;
      if ({grant, bus_req, busy} !== {8'h01, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL reset_first_grant: got grant=%h req=%b busy=%b want 01 1 1",
                  grant, bus_req, busy);
      end
   endtask

   task automatic test_rr_fairness();
      logic [7:0] exp_g [12];
      exp_g = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00,
                8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
      do_reset();
      dma = 8'h03;
      for (int i = 0; i < 12; i++) begin
         step();
         n_vec++;
         if (grant !== exp_g[i] || bus_req !== (exp_g[i] != 8'h00)) begin
            n_err++;
            $display("FAIL rr_fairness[%0d]: got grant=%h req=%b want grant=%h",
                     i, grant, bus_req, exp_g[i]);
         end
         ready = (exp_g[i] != 8'h00);
      end
      dma = '0;
      ready = 1'b0;
   endtask

   task automatic test_fixed_priority();
      logic [7:0] exp_g [9];
      exp_g = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
      do_reset();
      dma_fp = 8'h03;
      ready_fp = 1'b1;  // held high: also exercises BUS_ready outside GRANT
      for (int i = 0; i < 9; i++) begin
         step();
         n_vec++;
         if (grant_fp !== exp_g[i] || owner_fp !== 3'd0) begin
            n_err++;
            $display("FAIL fixed_priority[%0d]: got grant=%h owner=%0d want grant=%h owner=0",
                     i, grant_fp, owner_fp, exp_g[i]);
         end
      end
      dma_fp = '0;
      ready_fp = 1'b0;
   endtask

   task automatic test_watchdog();
      logic [7:0] exp_g [7];
      logic       exp_e [7];
      exp_g = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00, 8'h00, 8'h04};
      exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      do_reset();
      dma = 8'h04;
      for (int i = 0; i < 7; i++) begin
         step();
         n_vec++;
         if (grant !== exp_g[i] || terr !== exp_e[i]) begin
            n_err++;
            $display("FAIL watchdog[%0d]: got grant=%h terr=%b want grant=%h terr=%b",
                     i, grant, terr, exp_g[i], exp_e[i]);
         end
      end
      n_vec++;
      if (owner !== 3'd2) begin
         n_err++;
         $display("FAIL watchdog_owner: got %0d want 2", owner);
      end
      // Regrant happened on the last step; ready lands on the expiry edge.
      step();
      step();
      step();
      ready = 1'b1;
      step();
      n_vec++;
      if (grant !== 8'h00 || terr !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL ready_vs_expiry: got grant=%h terr=%b busy=%b want 00 0 1",
                  grant, terr, busy);
      end
      ready = 1'b0;
      dma = '0;
   endtask

   task automatic test_abort();
      do_reset();
      dma = 8'h02;
      step();
      n_vec++;
      if (grant !== 8'h02 || owner !== 3'd1) begin
         n_err++;
         $display("FAIL abort_grant: got grant=%h owner=%0d want 02 1", grant, owner);
      end
      dma = '0;
      step();
      n_vec++;
      if (grant !== 8'h00 || terr !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL abort_release: got grant=%h terr=%b busy=%b want 00 0 1",
                  grant, terr, busy);
      end
      step();
      n_vec++;
      if (busy !== 1'b0 || terr !== 1'b0) begin
         n_err++;
         $display("FAIL abort_idle: got busy=%b terr=%b want 0 0", busy, terr);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      dma = 8'h04;
      step();
      n_vec++;
      if (grant !== 8'h04 || owner !== 3'd2) begin
         n_err++;
         $display("FAIL midreset_grant: got grant=%h owner=%0d want 04 2", grant, owner);
      end
      clr = 1'b1;
      step();
      n_vec++;
      if ({grant, bus_req, owner, busy, terr} !== 14'h0 || dut.ptr_q !== 3'd0) begin
         n_err++;
         $display("FAIL midreset_clear: got grant=%h owner=%0d busy=%b ptr=%0d want all 0",
                  grant, owner, busy, dut.ptr_q);
      end
      clr = 1'b0;
      dma = 8'h81;
      step();
      n_vec++;
      if (grant !== 8'h01) begin
         n_err++;
         $display("FAIL midreset_regrant: got %h want 01", grant);
      end
      dma = '0;
   endtask

   task automatic test_ptr_wrap();
      do_reset();
      dma = 8'h40;
      step();
      n_vec++;
      if (grant !== 8'h40) begin
         n_err++;
         $display("FAIL wrap_setup: got %h want 40", grant);
      end
      dma = 8'h81;
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
      step();
      n_vec++;
      if (grant !== 8'h80 || owner !== 3'd7) begin
         n_err++;
         $display("FAIL wrap_ch7: got grant=%h owner=%0d want 80 7", grant, owner);
      end
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
      step();
      n_vec++;
      if (grant !== 8'h01 || owner !== 3'(CH_ICACHE)) begin
         n_err++;
         $display("FAIL wrap_ch0: got grant=%h owner=%0d want 01 0", grant, owner);
      end
      dma = '0;
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_fixed_priority();
      test_watchdog();
      test_abort();
      test_mid_reset();
      test_ptr_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
